// File: rtl/ecc_err_monitor.sv
// Post-corrector ECC monitor: 2-entry skid buffer, poison tagging, saturating error counters, first-error capture.
// Optional feature macro ECC_MON_IRQ_EN adds thresh_i/irq_o and a sticky interrupt.
module ecc_err_monitor #(
    parameter int DW   = 32,
    parameter int SW   = 7,
    parameter int AW   = 16,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_vld_i,
    output logic            in_rdy_o,
    input  logic [DW-1:0]   in_data_i,
    input  logic [AW-1:0]   in_addr_i,
    input  logic [SW-1:0]   in_syn_i,
    input  logic            in_sgl_i,
    input  logic            in_dbl_i,
    output logic            out_vld_o,
    input  logic            out_rdy_i,
    output logic [DW-1:0]   out_data_o,
    output logic [AW-1:0]   out_addr_o,
    output logic            out_psn_o,
    input  logic            clr_i,
    output logic [CNTW-1:0] sgl_cnt_o,
    output logic [CNTW-1:0] dbl_cnt_o,
    output logic            cap_vld_o,
    output logic [AW-1:0]   cap_addr_o,
    output logic [SW-1:0]   cap_syn_o,
    output logic            cap_dbl_o
`ifdef ECC_MON_IRQ_EN
    ,
    input  logic [CNTW-1:0] thresh_i,
    output logic            irq_o
`endif
);

    // Handshake: a word moves on a side when its valid and ready are both high at
    // the rising edge; valid holds its word until then. in_rdy_o is a pure register.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          psn;
    } word_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    word_t main_q, main_d, skid_q, skid_d, in_word;
    logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic  accept, sgl_ev, dbl_ev, err_ev;

    logic [CNTW-1:0] sgl_cnt_q, sgl_cnt_d, dbl_cnt_q, dbl_cnt_d, sgl_base, dbl_base;
    logic            cap_vld_q, cap_vld_d, cap_dbl_q, cap_dbl_d;
    logic [AW-1:0]   cap_addr_q, cap_addr_d;
    logic [SW-1:0]   cap_syn_q, cap_syn_d;

    assign in_rdy_o = ~skid_vld_q;
    assign accept   = in_vld_i & ~skid_vld_q;
    assign sgl_ev   = accept & in_sgl_i & ~in_dbl_i;
    assign dbl_ev   = accept & in_dbl_i;
    assign err_ev   = sgl_ev | dbl_ev;
    assign in_word  = '{data: in_data_i, addr: in_addr_i, psn: in_dbl_i};

    // The skid reg only fills when main is stalled, so it is always the older-but-one word.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || out_rdy_i) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = in_word;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_word;
            skid_vld_d = 1'b1;
        end
    end

    always_comb begin
        sgl_base   = clr_i ? '0 : sgl_cnt_q;
        dbl_base   = clr_i ? '0 : dbl_cnt_q;
        sgl_cnt_d  = sgl_base;
        dbl_cnt_d  = dbl_base;
        cap_vld_d  = clr_i ? 1'b0 : cap_vld_q;
        cap_dbl_d  = clr_i ? 1'b0 : cap_dbl_q;
        cap_addr_d = clr_i ? '0 : cap_addr_q;
        cap_syn_d  = clr_i ? '0 : cap_syn_q;
        if (sgl_ev && sgl_base != CNT_MAX) sgl_cnt_d = sgl_base + CNT_ONE;
        if (dbl_ev && dbl_base != CNT_MAX) dbl_cnt_d = dbl_base + CNT_ONE;
        // First error wins, except an uncorrectable word may replace a correctable one.
        if (err_ev && (!cap_vld_d || (!cap_dbl_d && dbl_ev))) begin
            cap_vld_d  = 1'b1;
            cap_dbl_d  = dbl_ev;
            cap_addr_d = in_addr_i;
            cap_syn_d  = in_syn_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            sgl_cnt_q  <= '0;
            dbl_cnt_q  <= '0;
            cap_vld_q  <= 1'b0;
            cap_dbl_q  <= 1'b0;
            cap_addr_q <= '0;
            cap_syn_q  <= '0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            sgl_cnt_q  <= sgl_cnt_d;
            dbl_cnt_q  <= dbl_cnt_d;
            cap_vld_q  <= cap_vld_d;
            cap_dbl_q  <= cap_dbl_d;
            cap_addr_q <= cap_addr_d;
            cap_syn_q  <= cap_syn_d;
        end
    end

    assign out_vld_o  = main_vld_q;
    assign out_data_o = main_q.data;
    assign out_addr_o = main_q.addr;
    assign out_psn_o  = main_q.psn;
    assign sgl_cnt_o  = sgl_cnt_q;
    assign dbl_cnt_o  = dbl_cnt_q;
    assign cap_vld_o  = cap_vld_q;
    assign cap_dbl_o  = cap_dbl_q;
    assign cap_addr_o = cap_addr_q;
    assign cap_syn_o  = cap_syn_q;

`ifdef ECC_MON_IRQ_EN
    logic irq_q, irq_d;

    // Threshold compares against the post-update count so the IRQ rises on the same edge.
    always_comb begin
        irq_d = clr_i ? 1'b0 : irq_q;
        if (dbl_ev) irq_d = 1'b1;
        if (thresh_i != '0 && sgl_cnt_d >= thresh_i) irq_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`endif

endmodule
